// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, receiver states and bit-timing helper.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

  // Clock cycles per line bit; tx and rx share this so their timing always matches.
  function automatic int calcClksPerBit(input int clkFreq, input int baudRate);
    return clkFreq / baudRate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with selectable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the async input through two flops so downstream logic only sees a settled level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-sampled bits, single-cycle byte/error pulses, break handling.
// CLKS_PER_BIT must be at least 4 so the half-bit and full-bit counts stay distinct.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = calcClksPerBit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic             rxS;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rxByte_q, rxByte_d;
  logic             rxValid_q, rxValid_d;
  logic             frameErr_q, frameErr_d;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rxSync (
    .clk   (clk),
    .resetn(resetn),
    .d_i   (rx),
    .q_o   (rxS)
  );

  // Frame FSM: qualify the start bit at half a bit, then step one full bit per sample.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    rxByte_d   = rxByte_q;
    rxValid_d  = 1'b0;
    frameErr_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxS) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rxS) begin
            state_d  = DATA;
            bitIdx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d             = '0;
          shift_d[bitIdx_q] = rxS;
          if (bitIdx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxS) begin
            rxByte_d  = shift_q;
            rxValid_d = 1'b1;
            state_d   = IDLE;
          end else begin
            frameErr_d = 1'b1;
            state_d    = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      WAIT_IDLE: begin
        cnt_d = '0;
        if (rxS) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress without a pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      rxByte_q   <= '0;
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      rxByte_q   <= rxByte_d;
      rxValid_q  <= rxValid_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign rx_byte   = rxByte_q;
  assign rx_valid  = rxValid_q;
  assign frame_err = frameErr_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;

  logic       clk;
  logic       resetn;
  logic       rx;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] expQ[$];
  int         expErr = 0;
  logic [7:0] expByte;
  int         lat;

  uart_rx #(
    .CLK_FREQ (1_000_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  // Free-running 100 MHz-style clock; inputs change and outputs are sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("[TB] FAIL %s got=%0d required=%0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Drive one 8N1 frame from a falling edge; bit periods alternate perA, perB, perA, ...
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input int perA, input int perB);
    logic [9:0] bits;
    bits = {stopBit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat ((i % 2 == 0) ? perA : perB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  // Monitor: every output pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rx_valid || frame_err) begin
      checkOutput("validErrExclusive", {31'd0, rx_valid & frame_err}, 32'd0);
    end
    if (rx_valid) begin
      checkOutput("validExpected", {31'd0, expQ.size() > 0}, 32'd1);
      if (expQ.size() > 0) begin
        expByte = expQ.pop_front();
        checkOutput("rxByte", {24'd0, rx_byte}, {24'd0, expByte});
      end
    end
    if (frame_err) begin
      checkOutput("frameErrExpected", {31'd0, expErr > 0}, 32'd1);
      if (expErr > 0) expErr--;
    end
  end

  // Watchdog so a stuck run still terminates with a visible failure.
  initial begin
    #500us;
    $display("[TB] FAIL watchdog got=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios in sequence.
  initial begin
    rx     = 1'b1;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetByte", {24'd0, rx_byte}, 32'd0);
    checkOutput("resetValid", {31'd0, rx_valid}, 32'd0);
    checkOutput("resetErr", {31'd0, frame_err}, 32'd0);
    checkOutput("resetBusy", {31'd0, rx_busy}, 32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame with latency measurement from the start edge.
    $display("[TB] single frame 0xA5");
    expQ.push_back(8'hA5);
    lat = 0;
    fork
      applyStimulus(8'hA5, 1'b1, 10, 10);
      begin
        while (!rx_valid && lat < 200) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    checkRange("latency", lat, 97, 99);
    repeat (20) @(negedge clk);
    checkOutput("busyAfterFrame", {31'd0, rx_busy}, 32'd0);

    // Back-to-back frames as a transmitter would send them.
    $display("[TB] back-to-back frames");
    expQ.push_back(8'h00);
    expQ.push_back(8'hFF);
    expQ.push_back(8'h55);
    expQ.push_back(8'h80);
    applyStimulus(8'h00, 1'b1, 10, 10);
    applyStimulus(8'hFF, 1'b1, 10, 10);
    applyStimulus(8'h55, 1'b1, 10, 10);
    applyStimulus(8'h80, 1'b1, 10, 10);
    repeat (20) @(negedge clk);

    // Start-bit glitch of 3 cycles must be rejected.
    $display("[TB] start glitch");
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    checkOutput("glitchBusyRose", {31'd0, rx_busy}, 32'd1);
    lat = 0;
    while (rx_busy && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkRange("glitchBusyFall", lat, 1, 8);
    repeat (20) @(negedge clk);
    expQ.push_back(8'h3C);
    applyStimulus(8'h3C, 1'b1, 10, 10);
    repeat (20) @(negedge clk);

    // Framing error followed by a break.
    $display("[TB] framing error and break");
    expErr++;
    applyStimulus(8'h12, 1'b0, 10, 10);
    checkOutput("byteHeldOnErr", {24'd0, rx_byte}, 32'h3C);
    rx = 1'b0;
    repeat (50) @(negedge clk);
    checkOutput("busyInBreak", {31'd0, rx_busy}, 32'd1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("busyAfterBreak", {31'd0, rx_busy}, 32'd0);
    repeat (10) @(negedge clk);
    expQ.push_back(8'h34);
    applyStimulus(8'h34, 1'b1, 10, 10);
    repeat (20) @(negedge clk);

    // Asynchronous reset during data bit 4, released while the line is high.
    $display("[TB] reset mid-frame");
    fork
      applyStimulus(8'hC3, 1'b1, 10, 10);
      begin
        repeat (53) @(negedge clk);
        checkOutput("busyBeforeReset", {31'd0, rx_busy}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("midResetByte", {24'd0, rx_byte}, 32'd0);
        checkOutput("midResetValid", {31'd0, rx_valid}, 32'd0);
        checkOutput("midResetErr", {31'd0, frame_err}, 32'd0);
        checkOutput("midResetBusy", {31'd0, rx_busy}, 32'd0);
        repeat (19) @(negedge clk);
        resetn = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    expQ.push_back(8'h7E);
    applyStimulus(8'h7E, 1'b1, 10, 10);
    repeat (20) @(negedge clk);

    // Bit-period jitter: alternating 9/11 and 11/9 clocks per bit.
    $display("[TB] bit period jitter");
    expQ.push_back(8'h96);
    applyStimulus(8'h96, 1'b1, 9, 11);
    repeat (20) @(negedge clk);
    expQ.push_back(8'h96);
    applyStimulus(8'h96, 1'b1, 11, 9);
    repeat (20) @(negedge clk);

    checkOutput("pendingBytes", expQ.size(), 32'd0);
    checkOutput("pendingErrs", expErr, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
